// File: rtl/ula_multiciclo.sv
// ula_multiciclo: registered ALU with a start/busy/done handshake.
// Single-cycle ops complete on the accepting edge. MUL (shift-add) and DIVU
// (restoring shift-subtract) iterate for WIDTH cycles in the ITER state.
// Z/N flags come from the registered result. C/V depend on the operation.
module ula_multiciclo #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] scra,
    input  logic [WIDTH-1:0] scrb,
    input  logic [3:0]       ula_control,
    output logic [WIDTH-1:0] ula_result,
    output logic             flagz,
    output logic             flagn,
    output logic             flagc,
    output logic             flagv,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic {S_IDLE, S_ITER} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_z, r_n, r_c, r_v, r_done;
    // r_hi: MUL partial product high half / DIVU remainder
    // r_lo: MUL multiplier (shifting out) / DIVU dividend->quotient
    logic [WIDTH-1:0] r_hi, r_lo, r_opb;
    logic             r_is_mul;
    logic [SHW-1:0]   r_cnt;

    logic             w_fire_single, w_accept_iter, w_finish, w_is_iter_op;
    logic [WIDTH:0]   w_add, w_sub;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c, w_alu_v;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff, w_div_hi, w_div_lo;
    logic             w_ge;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c, w_fin_v;

    assign w_add = {1'b0, scra} + {1'b0, scrb};
    assign w_sub = {1'b0, scra} + {1'b0, ~scrb} + (WIDTH+1)'(1);
    assign w_is_iter_op = (ula_control == OP_MUL) || (ula_control == OP_DIVU);

    // Single-cycle ALU result and carry/overflow from the live operands
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (ula_control)
            OP_AND: w_alu_res = scra & scrb;
            OP_OR:  w_alu_res = scra | scrb;
            OP_XOR: w_alu_res = scra ^ scrb;
            OP_ADD: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
                w_alu_v   = (scra[WIDTH-1] == scrb[WIDTH-1]) &&
                            (w_add[WIDTH-1] != scra[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_sub[WIDTH-1:0];
                w_alu_c   = w_sub[WIDTH];
                w_alu_v   = (scra[WIDTH-1] != scrb[WIDTH-1]) &&
                            (w_sub[WIDTH-1] != scra[WIDTH-1]);
            end
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(scra) < $signed(scrb))};
            OP_SLL: w_alu_res = scra << scrb[SHW-1:0];
            OP_SRL: w_alu_res = scra >> scrb[SHW-1:0];
            default: w_alu_res = '0;
        endcase
    end

    // One iteration step: shift-add multiply and restoring divide
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_opb});
        w_diff    = WIDTH'(w_rem_sh - {1'b0, r_opb});
        w_div_hi  = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
        w_div_lo  = {r_lo[WIDTH-2:0], w_ge};
        // A zero divisor always "fits", so the quotient naturally ends all ones
        w_fin_res = r_is_mul ? w_mul_lo : w_div_lo;
        w_fin_c   = r_is_mul ? (|w_mul_hi) : 1'b0;
        w_fin_v   = r_is_mul ? 1'b0 : (r_opb == '0);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state and control strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_fire_single = 1'b0;
        w_accept_iter = 1'b0;
        w_finish      = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                if (w_is_iter_op) begin
                    w_accept_iter = 1'b1;
                    w_state_nxt   = S_ITER;
                end else begin
                    w_fire_single = 1'b1;
                end
            end
            S_ITER: if (r_cnt == SHW'(WIDTH-1)) begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration registers, result/flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_is_mul <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_fire_single) begin
                r_result <= w_alu_res;
                r_z      <= (w_alu_res == '0);
                r_n      <= w_alu_res[WIDTH-1];
                r_c      <= w_alu_c;
                r_v      <= w_alu_v;
                r_done   <= 1'b1;
            end
            if (w_accept_iter) begin
                r_hi     <= '0;
                r_lo     <= scra;
                r_opb    <= scrb;
                r_is_mul <= (ula_control == OP_MUL);
                r_cnt    <= '0;
            end
            if (r_state == S_ITER) begin
                r_hi  <= r_is_mul ? w_mul_hi : w_div_hi;
                r_lo  <= r_is_mul ? w_mul_lo : w_div_lo;
                r_cnt <= r_cnt + SHW'(1);
            end
            if (w_finish) begin
                r_result <= w_fin_res;
                r_z      <= (w_fin_res == '0);
                r_n      <= w_fin_res[WIDTH-1];
                r_c      <= w_fin_c;
                r_v      <= w_fin_v;
                r_done   <= 1'b1;
            end
        end
    end

    assign ula_result = r_result;
    assign flagz      = r_z;
    assign flagn      = r_n;
    assign flagc      = r_c;
    assign flagv      = r_v;
    assign done       = r_done;
    assign busy       = (r_state == S_ITER);

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo (WIDTH=8): a vector table for the
// single-cycle ops plus hand sequences for MUL/DIVU latency and reset.
module tb_ula_multiciclo;
    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] scra = '0, scrb = '0;
    logic [3:0]   ula_control = '0;
    logic [W-1:0] ula_result;
    logic         flagz, flagn, flagc, flagv, busy, done;

    int checks = 0, errors = 0;

    ula_multiciclo #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .scra(scra), .scrb(scrb),
        .ula_control(ula_control), .ula_result(ula_result),
        .flagz(flagz), .flagn(flagn), .flagc(flagc), .flagv(flagv),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic         z, n, c, v;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] res,
                           input logic z, input logic n, input logic c, input logic v);
        chk({name, " result"}, 32'(ula_result), 32'(res));
        chk({name, " flags zncv"}, {28'd0, flagz, flagn, flagc, flagv}, {28'd0, z, n, c, v});
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; ula_control = op; scra = a; scrb = b;
        @(posedge clk); #1;
    endtask

    // Multi-cycle op: checks busy/done every cycle and the WIDTH-cycle latency
    task automatic run_iter(input string name, input logic [3:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb,
                            input logic [W-1:0] res, input logic z, input logic n,
                            input logic c, input logic v);
        logic [W-1:0] prev;
        issue(op, a, b);
        prev = ula_result;
        chk({name, " accept busy"}, 32'(busy), 32'd1);
        chk({name, " accept done"}, 32'(done), 32'd0);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            start = disturb && (k < W);
            ula_control = 4'b0010;
            scra = 8'(k * 37);
            scrb = 8'(k * 11 + 1);
            @(posedge clk); #1;
            if (k < W) begin
                chk($sformatf("%s c%0d busy", name, k), 32'(busy), 32'd1);
                chk($sformatf("%s c%0d done", name, k), 32'(done), 32'd0);
                chk($sformatf("%s c%0d held", name, k), 32'(ula_result), 32'(prev));
            end else begin
                chk({name, " done"}, 32'(done), 32'd1);
                chk({name, " busy end"}, 32'(busy), 32'd0);
                chk_out(name, res, z, n, c, v);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //             op       a      b      res    z     n     c     v
        vecs[0]  = '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}; // ADD carry
        vecs[1]  = '{4'b0110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1}; // SUB ovf
        vecs[2]  = '{4'b0111, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0}; // SLT -1<1
        vecs[3]  = '{4'b0100, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0}; // SLL by 1
        vecs[4]  = '{4'b0101, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0}; // SRL by 7
        vecs[5]  = '{4'b0011, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0}; // XOR
        vecs[6]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0}; // AND
        vecs[7]  = '{4'b0001, 8'h0F, 8'h80, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0}; // OR
        vecs[8]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1}; // ADD ovf
        vecs[9]  = '{4'b0110, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0}; // SUB borrow
        vecs[10] = '{4'b0110, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}; // SUB equal
        vecs[11] = '{4'b0111, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}; // SLT 1<-1 no
        vecs[12] = '{4'b0100, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0}; // SLL by 0
        vecs[13] = '{4'b1111, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}; // undefined
        vecs[14] = '{4'b0111, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0}; // SLT -128<127

        // Reset state
        #12;
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("idle done", 32'(done), 32'd0);

        // Single-cycle table, issued back-to-back on consecutive cycles
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            chk_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v);
            chk($sformatf("vec%0d done", i), 32'(done), 32'd1);
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
        end
        @(negedge clk) start = 1'b0;
        @(posedge clk); #1;
        chk("single done pulse", 32'(done), 32'd0);
        chk("single hold", 32'(ula_result), 32'h01);

        // Multi-cycle ops
        run_iter("mul10x11", 4'b1000, 8'h10, 8'h11, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
        // start during the done cycle is accepted
        issue(4'b0010, 8'h01, 8'h01);
        chk_out("b2b add", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b done", 32'(done), 32'd1);
        run_iter("mul0Fx11", 4'b1000, 8'h0F, 8'h11, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_iter("mulFFxFF", 4'b1000, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        run_iter("div64_07", 4'b1001, 8'h64, 8'h07, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0);
        run_iter("div05_00", 4'b1001, 8'h05, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
        run_iter("div07_09", 4'b1001, 8'h07, 8'h09, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_iter("divFF_01", 4'b1001, 8'hFF, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk) start = 1'b0;
        @(posedge clk); #1;
        chk("iter done pulse", 32'(done), 32'd0);
        chk("iter hold", 32'(ula_result), 32'hFF);

        // Asynchronous reset three cycles into a MUL
        issue(4'b1000, 8'h03, 8'h05);
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_out("async rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post rst c%0d done", k), 32'(done), 32'd0);
            chk($sformatf("post rst c%0d busy", k), 32'(busy), 32'd0);
        end
        issue(4'b0010, 8'h02, 8'h03);
        chk_out("add after rst", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add after rst done", 32'(done), 32'd1);
        @(negedge clk) start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
